// File: rtl/in_wrapper_pkg.sv
// Shared definitions for the FP-core input wrapper.
//   WIDTH_DEF : default operand/bus width (IEEE-754 binary32)
//   state_t   : 3-bit controller state encoding
package in_wrapper_pkg;

  localparam int unsigned WIDTH_DEF = 32;

  typedef enum logic [2:0] {
    IDLE_A    = 3'd0,
    LOAD_A    = 3'd1,
    ACK_A     = 3'd2,
    WAIT_B    = 3'd3,
    LOAD_B    = 3'd4,
    ACK_B     = 3'd5,
    START     = 3'd6,
    WAIT_DONE = 3'd7
  } state_t;

endpackage

// File: rtl/in_wrapper_if.sv
// Producer-side four-phase handshake bundle for the FP-core input wrapper.
//   inBus      : operand word, valid and stable while inReady=1
//   inReady    : producer has a word on inBus (level)
//   inAccepted : wrapper captured the word; held until inReady falls
// Modports: master = producer, slave = wrapper.
interface in_wrapper_if
  import in_wrapper_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF
);

  logic [WIDTH-1:0] inBus;
  logic             inReady;
  logic             inAccepted;

  modport master (output inBus, output inReady, input inAccepted);
  modport slave  (input inBus, input inReady, output inAccepted);

endinterface

// File: rtl/in_wrapper_cu.sv
// Moore controller for the input wrapper: sequences capture of operand A,
// then operand B, issues a single start pulse and waits for the core.
//   clk, rst       : clock, asynchronous active-high reset
//   i_inReady      : producer word-valid level
//   i_doneFP       : core finished (only looked at in WAIT_DONE)
//   o_loadA/o_loadB: operand register load strobes
//   o_inAccepted   : handshake acknowledge
//   o_startFP      : one-cycle start pulse to the core
//   o_busy         : operation in progress
module in_wrapper_cu
  import in_wrapper_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic i_inReady,
  input  logic i_doneFP,
  output logic o_loadA,
  output logic o_loadB,
  output logic o_inAccepted,
  output logic o_startFP,
  output logic o_busy
);

  state_t r_state;
  state_t w_next;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE_A;
    else     r_state <= w_next;
  end

  // Outputs depend on state only, so every control output is glitch-free
  // with respect to producer and core inputs.
  always_comb begin
    w_next       = r_state;
    o_loadA      = 1'b0;
    o_loadB      = 1'b0;
    o_inAccepted = 1'b0;
    o_startFP    = 1'b0;
    o_busy       = 1'b0;
    unique case (r_state)
      IDLE_A: begin
        if (i_inReady) w_next = LOAD_A;
      end
      LOAD_A: begin
        o_loadA = 1'b1;
        o_busy  = 1'b1;
        w_next  = ACK_A;
      end
      ACK_A: begin
        o_inAccepted = 1'b1;
        o_busy       = 1'b1;
        if (!i_inReady) w_next = WAIT_B;
      end
      WAIT_B: begin
        o_busy = 1'b1;
        if (i_inReady) w_next = LOAD_B;
      end
      LOAD_B: begin
        o_loadB = 1'b1;
        o_busy  = 1'b1;
        w_next  = ACK_B;
      end
      ACK_B: begin
        o_inAccepted = 1'b1;
        o_busy       = 1'b1;
        if (!i_inReady) w_next = START;
      end
      // doneFP is deliberately ignored here: a level left over from the
      // previous operation must not short-circuit the new one.
      START: begin
        o_startFP = 1'b1;
        o_busy    = 1'b1;
        w_next    = WAIT_DONE;
      end
      WAIT_DONE: begin
        o_busy = 1'b1;
        if (i_doneFP) w_next = IDLE_A;
      end
      default: w_next = IDLE_A;
    endcase
  end

endmodule

// File: rtl/in_wrapper.sv
// Input-side wrapper for the IEEE-754 single-precision FP core. Collects
// operand A then operand B from a shared bus via a four-phase handshake,
// holds them stable, pulses startFP and blocks new operands until doneFP.
// Operands are passed through bit-exact (no FP interpretation).
//   clk, rst : clock, asynchronous active-high reset
//   bus      : producer handshake (inBus/inReady/inAccepted), slave side
//   doneFP   : core finished (level)
//   startFP  : one-cycle start pulse
//   opA, opB : registered operands
//   busy     : from first capture of A until doneFP accepted
module in_wrapper
  import in_wrapper_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  in_wrapper_if.slave      bus,
  input  logic             doneFP,
  output logic             startFP,
  output logic [WIDTH-1:0] opA,
  output logic [WIDTH-1:0] opB,
  output logic             busy
);

  logic             w_loadA;
  logic             w_loadB;
  logic             w_inAccepted;
  logic [WIDTH-1:0] r_opA;
  logic [WIDTH-1:0] r_opB;

  in_wrapper_cu u_cu (
    .clk          (clk),
    .rst          (rst),
    .i_inReady    (bus.inReady),
    .i_doneFP     (doneFP),
    .o_loadA      (w_loadA),
    .o_loadB      (w_loadB),
    .o_inAccepted (w_inAccepted),
    .o_startFP    (startFP),
    .o_busy       (busy)
  );

  // Operands are cleared on reset so an aborted transfer leaves no
  // partial operand visible to the core.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)          r_opA <= '0;
    else if (w_loadA) r_opA <= bus.inBus;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)          r_opB <= '0;
    else if (w_loadB) r_opB <= bus.inBus;
  end

  assign bus.inAccepted = w_inAccepted;
  assign opA            = r_opA;
  assign opB            = r_opB;

endmodule

// File: tb/tb_in_wrapper.sv
// Directed bench for in_wrapper: reset/idle, nominal transfer, slow
// producer, back-pressure during WAIT_DONE, reset mid-operation, stale done.
// Expected operand pairs are queued when stimulus is driven and compared
// when the wrapper issues startFP.
module tb_in_wrapper;

  logic        clk;
  logic        rst;
  logic        doneFP;
  logic        startFP;
  logic [31:0] opA;
  logic [31:0] opB;
  logic        busy;

  int errors = 0;
  int checks = 0;
  int start_cnt = 0;

  logic [63:0] sb[$];

  in_wrapper_if #(.WIDTH(32)) u_if ();

  in_wrapper #(.WIDTH(32)) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (u_if),
    .doneFP  (doneFP),
    .startFP (startFP),
    .opA     (opA),
    .opB     (opB),
    .busy    (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (startFP === 1'b1) start_cnt++;

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic wait_acc(input logic lvl, input string tag);
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (u_if.inAccepted === lvl) return;
    end
    chk1({tag, "_timeout"}, u_if.inAccepted, lvl);
  endtask

  // Full four-phase word transfer; after capture the bus is corrupted to
  // show that the register does not reload while inReady is still high.
  task automatic send_word(input logic [31:0] w, input int hold, output int hi_cnt);
    u_if.inBus   = w;
    u_if.inReady = 1'b1;
    wait_acc(1'b1, "acc_rise");
    hi_cnt = 0;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      if (u_if.inAccepted === 1'b1) hi_cnt++;
      if (i == 0) u_if.inBus = ~w;
    end
    u_if.inReady = 1'b0;
    wait_acc(1'b0, "acc_fall");
  endtask

  task automatic wait_start();
    logic [63:0] e;
    for (int n = 0; n < 30 && startFP !== 1'b1; n++) @(negedge clk);
    chk1("start_seen", startFP, 1'b1);
    if (sb.size() > 0) e = sb.pop_front();
    else e = 64'hDEAD_BEEF_DEAD_BEEF;
    chk("opA_at_start", opA, e[63:32]);
    chk("opB_at_start", opB, e[31:0]);
    @(negedge clk);
    chk1("start_one_cycle", startFP, 1'b0);
    chk1("busy_wait_done", busy, 1'b1);
  endtask

  task automatic finish_op();
    int bad = 0;
    repeat (3) begin
      @(negedge clk);
      if (busy !== 1'b1) bad++;
    end
    chk("busy_until_done", bad, 0);
    doneFP = 1'b1;
    @(negedge clk);
    doneFP = 1'b0;
    chk1("busy_after_done", busy, 1'b0);
  endtask

  initial begin
    int hi;
    int viol;
    int snap;

    rst = 1'b1; doneFP = 1'b0;
    u_if.inBus = '0; u_if.inReady = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Reset then idle
    chk("rst_opA", opA, 32'h0);
    chk("rst_opB", opB, 32'h0);
    chk1("rst_inAccepted", u_if.inAccepted, 1'b0);
    chk1("rst_startFP", startFP, 1'b0);
    chk1("rst_busy", busy, 1'b0);
    viol = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (opA !== 0 || opB !== 0 || u_if.inAccepted !== 1'b0 || startFP !== 1'b0 || busy !== 1'b0)
        viol++;
    end
    chk("idle_100", viol, 0);

    // Nominal transfer with cycle-exact latency
    sb.push_back({32'h3F800000, 32'h40000000});
    u_if.inBus = 32'h3F800000; u_if.inReady = 1'b1;
    @(negedge clk);
    chk1("lat_acc_load_a", u_if.inAccepted, 1'b0);
    chk1("lat_busy_load_a", busy, 1'b1);
    @(negedge clk);
    chk1("lat_acc_ack_a", u_if.inAccepted, 1'b1);
    chk("lat_opA", opA, 32'h3F800000);
    u_if.inReady = 1'b0;
    wait_acc(1'b0, "nom_acc_fall");
    send_word(32'h40000000, 0, hi);
    chk1("start_latency", startFP, 1'b1);
    snap = start_cnt;
    wait_start();
    finish_op();
    chk("nom_one_start", start_cnt - snap, 1);

    // Slow producer, NaN and denormal passed through bit-exact
    sb.push_back({32'h7FC00001, 32'h00000001});
    send_word(32'h7FC00001, 50, hi);
    chk("slow_acc_hi_A", hi, 50);
    chk("slow_opA_held", opA, 32'h7FC00001);
    send_word(32'h00000001, 50, hi);
    chk("slow_acc_hi_B", hi, 50);
    chk("slow_opB_held", opB, 32'h00000001);
    wait_start();
    finish_op();

    // Back-pressure: new word offered while core is busy
    sb.push_back({32'h40400000, 32'h40800000});
    send_word(32'h40400000, 0, hi);
    send_word(32'h40800000, 0, hi);
    wait_start();
    sb.push_back({32'hC0490FDB, 32'h3F000000});
    u_if.inBus = 32'hC0490FDB; u_if.inReady = 1'b1;
    viol = 0;
    repeat (5) begin
      @(negedge clk);
      if (u_if.inAccepted !== 1'b0) viol++;
    end
    chk("bp_no_accept", viol, 0);
    chk("bp_opA_held", opA, 32'h40400000);
    doneFP = 1'b1;
    @(negedge clk);
    doneFP = 1'b0;
    chk1("bp_idle_after_done", busy, 1'b0);
    wait_acc(1'b1, "bp_acc_rise");
    chk("bp_opA_captured", opA, 32'hC0490FDB);
    u_if.inReady = 1'b0;
    wait_acc(1'b0, "bp_acc_fall");
    send_word(32'h3F000000, 0, hi);
    wait_start();
    finish_op();

    // Reset mid-operation (in WAIT_B)
    send_word(32'h41200000, 0, hi);
    chk1("mid_busy_wait_b", busy, 1'b1);
    chk("mid_opA_loaded", opA, 32'h41200000);
    snap = start_cnt;
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_opA_async", opA, 32'h0);
    chk1("mid_rst_busy", busy, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    chk("mid_rst_no_start", start_cnt - snap, 0);
    chk1("mid_rst_idle", busy, 1'b0);
    sb.push_back({32'h41200000, 32'h41A00000});
    send_word(32'h41200000, 0, hi);
    send_word(32'h41A00000, 0, hi);
    wait_start();
    finish_op();

    // Stale doneFP held across START
    sb.push_back({32'h3F800000, 32'hBF800000});
    send_word(32'h3F800000, 0, hi);
    doneFP = 1'b1;
    snap = start_cnt;
    send_word(32'hBF800000, 0, hi);
    wait_start();
    @(negedge clk);
    chk1("stale_leave_wait_done", busy, 1'b0);
    repeat (10) @(negedge clk);
    chk("stale_single_start", start_cnt - snap, 1);
    chk1("stale_stay_idle", busy, 1'b0);
    doneFP = 1'b0;

    chk("sb_drained", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
